// File: rtl/keypad_operand_entry.sv
// -----------------------------------------------------------------------------
// keypad_operand_entry
//
// Turns a stream of decoded keypad codes into a signed two's-complement
// operand for the Booth multiplier. Decimal digits are accumulated into a
// binary magnitude using a shift-and-add multiply by ten:
//   mag*10 + d = (mag<<3) + (mag<<1) + d
// This is spread over two busy cycles (MUL8 then ADD). While the entry is in
// progress, a BCD echo of the typed digits is kept for the 7-segment display.
// A finished operand is offered with a valid/ready handshake and held until
// the consumer takes it.
//
// Key codes: 0x0-0x9 digit, 0xA sign toggle, 0xB enter, 0xC clear,
//            0xD-0xF ignored.
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-low
//   key_valid    one-cycle pulse; key_code is valid this cycle
//   key_code     decoded key
//   op_ready     consumer is ready for the operand
//   op_valid     op_value is valid and held
//   op_value     signed operand, WIDTH bits
//   neg          current sign of the entry
//   mag_bcd      BCD echo of entered digits; least-significant digit in [3:0]
//   digit_count  number of digits accepted so far
//   busy         update in progress or operand pending; keys are dropped
//   overflow     sticky error flag; cleared by clear, enter or handshake
// -----------------------------------------------------------------------------
module keypad_operand_entry #(
  parameter int WIDTH      = 8,
  parameter int MAX_DIGITS = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_valid,
  input  logic [3:0]                         key_code,
  input  logic                               op_ready,
  output logic                               op_valid,
  output logic [WIDTH-1:0]                   op_value,
  output logic                               neg,
  output logic [4*MAX_DIGITS-1:0]            mag_bcd,
  output logic [$clog2(MAX_DIGITS+1)-1:0]    digit_count,
  output logic                               busy,
  output logic                               overflow
);

  // Magnitude needs two spare bits over WIDTH so that +128 (for -128) and
  // the intermediate mag<<3 fit without wrapping.
  localparam int MAG_W  = WIDTH + 2;
  localparam int CAND_W = MAG_W + 4;
  localparam int CNT_W  = $clog2(MAX_DIGITS + 1);
  localparam int BCD_W  = 4 * MAX_DIGITS;

  localparam logic [CAND_W-1:0] LIMIT_POS = CAND_W'((1 << (WIDTH - 1)) - 1);
  localparam logic [CAND_W-1:0] LIMIT_NEG = CAND_W'(1 << (WIDTH - 1));
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_DIGITS);

  localparam logic [3:0] KEY_SIGN  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    S_IDLE,   // no digits entered
    S_ENTRY,  // at least one digit entered
    S_MUL8,   // mag_tmp <= mag<<3
    S_ADD,    // mag <= mag_tmp + (mag<<1) + digit
    S_HOLD    // operand offered downstream
  } state_t;

  state_t             state_q;
  logic [MAG_W-1:0]   mag_q;
  logic [MAG_W-1:0]   mag_tmp_q;
  logic [3:0]         digit_q;
  logic               neg_q;
  logic [BCD_W-1:0]   mag_bcd_q;
  logic [CNT_W-1:0]   digit_cnt_q;
  logic               op_valid_q;
  logic [WIDTH-1:0]   op_value_q;
  logic               busy_q;
  logic               overflow_q;

  // ---------------------------------------------------------------------------
  // Combinational decisions evaluated at the key edge
  // ---------------------------------------------------------------------------
  logic [CAND_W-1:0] mag_ext;
  logic [CAND_W-1:0] cand_d;
  logic [CAND_W-1:0] limit;
  logic              digit_ok;
  logic              sign_ok;
  logic [MAG_W-1:0]  mag_d;
  logic [WIDTH-1:0]  op_mag;
  logic [WIDTH-1:0]  op_value_d;

  assign mag_ext  = {4'd0, mag_q};
  // Range check is done on the full product up front so a rejected digit
  // never disturbs the accumulated magnitude.
  assign cand_d   = (mag_ext << 3) + (mag_ext << 1) + CAND_W'(key_code);
  assign limit    = neg_q ? LIMIT_NEG : LIMIT_POS;
  assign digit_ok = (digit_cnt_q != MAX_CNT) && (cand_d <= limit);

  // Flipping -128 to positive would produce an unrepresentable +128.
  assign sign_ok  = !(neg_q && (mag_ext == LIMIT_NEG));

  assign mag_d    = mag_tmp_q + (mag_q << 1) + MAG_W'(digit_q);

  // Magnitude never exceeds 2**(WIDTH-1), so its low WIDTH bits carry the
  // full value; negating them yields the correct two's complement (and -0=0).
  assign op_mag     = mag_q[WIDTH-1:0];
  assign op_value_d = neg_q ? (WIDTH'(0) - op_mag) : op_mag;

  // ---------------------------------------------------------------------------
  // State machine and all registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= only, so every register in
  // this block samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      mag_q       <= '0;
      mag_tmp_q   <= '0;
      digit_q     <= '0;
      neg_q       <= 1'b0;
      mag_bcd_q   <= '0;
      digit_cnt_q <= '0;
      op_valid_q  <= 1'b0;
      op_value_q  <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ENTRY: begin
          if (key_valid) begin
            case (key_code) inside
              [4'h0:4'h9]: begin
                if (digit_ok) begin
                  digit_q <= key_code;
                  state_q <= S_MUL8;
                  busy_q  <= 1'b1;
                end else begin
                  overflow_q <= 1'b1;
                end
              end
              KEY_SIGN: begin
                if (sign_ok) neg_q      <= ~neg_q;
                else         overflow_q <= 1'b1;
              end
              KEY_ENTER: begin
                // Enter with nothing typed is meaningless and ignored.
                if (state_q == S_ENTRY) begin
                  op_value_q <= op_value_d;
                  op_valid_q <= 1'b1;
                  overflow_q <= 1'b0;
                  busy_q     <= 1'b1;
                  state_q    <= S_HOLD;
                end
              end
              KEY_CLEAR: begin
                mag_q       <= '0;
                mag_bcd_q   <= '0;
                digit_cnt_q <= '0;
                neg_q       <= 1'b0;
                overflow_q  <= 1'b0;
                state_q     <= S_IDLE;
              end
              default: ; // unused codes have no effect
            endcase
          end
        end

        S_MUL8: begin
          mag_tmp_q <= mag_q << 3;
          state_q   <= S_ADD;
        end

        S_ADD: begin
          mag_q       <= mag_d;
          mag_bcd_q   <= {mag_bcd_q[BCD_W-5:0], digit_q};
          digit_cnt_q <= digit_cnt_q + CNT_W'(1);
          busy_q      <= 1'b0;
          state_q     <= S_ENTRY;
        end

        S_HOLD: begin
          // op_valid is always high here, so op_ready alone completes the
          // transfer. Any key arriving on this edge is dropped.
          if (op_ready) begin
            op_valid_q  <= 1'b0;
            mag_q       <= '0;
            mag_bcd_q   <= '0;
            digit_cnt_q <= '0;
            neg_q       <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign op_valid    = op_valid_q;
  assign op_value    = op_value_q;
  assign neg         = neg_q;
  assign mag_bcd     = mag_bcd_q;
  assign digit_count = digit_cnt_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// -----------------------------------------------------------------------------
// Self-checking bench for keypad_operand_entry.
// A behavioural model (integer magnitude, queue of typed digits, a countdown
// for the two-cycle update, a hold flag) is advanced on every clock edge with
// the same inputs the DUT sees and compared against the DUT one time unit
// after the edge. Directed scenarios are followed by a randomized key stream.
// -----------------------------------------------------------------------------
module tb_keypad_operand_entry;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        op_ready;
  logic        op_valid;
  logic [7:0]  op_value;
  logic        neg;
  logic [11:0] mag_bcd;
  logic [1:0]  digit_count;
  logic        busy;
  logic        overflow;

  keypad_operand_entry #(.WIDTH(8), .MAX_DIGITS(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .op_ready    (op_ready),
    .op_valid    (op_valid),
    .op_value    (op_value),
    .neg         (neg),
    .mag_bcd     (mag_bcd),
    .digit_count (digit_count),
    .busy        (busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  int m_mag, m_neg, m_ovf, m_pend, m_pdig, m_hold, m_opval;
  int m_digits[$];

  function automatic int m_bcd();
    int v = 0;
    foreach (m_digits[i]) v = (v << 4) | m_digits[i];
    return v;
  endfunction

  task automatic model_reset();
    m_mag = 0; m_neg = 0; m_ovf = 0; m_pend = 0; m_pdig = 0;
    m_hold = 0; m_opval = 0;
    m_digits.delete();
  endtask

  task automatic model_clear();
    m_mag = 0; m_neg = 0; m_ovf = 0;
    m_digits.delete();
  endtask

  // One clock edge of behaviour, from the rules: a busy entry drops keys.
  task automatic model_step(input int kv, input int kc, input int rdy);
    if (m_hold != 0) begin
      if (rdy != 0) begin
        m_hold = 0;
        model_clear();
      end
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        m_mag = m_mag * 10 + m_pdig;
        m_digits.push_back(m_pdig);
      end
    end else if (kv != 0) begin
      if (kc <= 9) begin
        if (m_digits.size() == 3 || m_mag * 10 + kc > (m_neg != 0 ? 128 : 127))
          m_ovf = 1;
        else begin
          m_pend = 2;
          m_pdig = kc;
        end
      end else if (kc == 10) begin
        if (m_neg != 0 && m_mag == 128) m_ovf = 1;
        else m_neg = (m_neg != 0) ? 0 : 1;
      end else if (kc == 11) begin
        if (m_digits.size() > 0) begin
          m_opval = (m_neg != 0 ? -m_mag : m_mag) & 255;
          m_hold  = 1;
          m_ovf   = 0;
        end
      end else if (kc == 12) begin
        model_clear();
      end
    end
  endtask

  task automatic compare_all();
    check("op_valid", int'(op_valid), m_hold);
    check("busy", int'(busy), (m_hold != 0 || m_pend > 0) ? 1 : 0);
    check("neg", int'(neg), m_neg);
    check("overflow", int'(overflow), m_ovf);
    check("digit_count", int'(digit_count), m_digits.size());
    check("mag_bcd", int'(mag_bcd), m_bcd());
    if (m_hold != 0) check("op_value", int'(op_value), m_opval);
  endtask

  // Drive one cycle of inputs, advance DUT and model, compare.
  task automatic step(input int kv, input int kc, input int rdy);
    key_valid = kv[0];
    key_code  = 4'(kc);
    op_ready  = rdy[0];
    @(posedge clk);
    model_step(kv, kc, rdy);
    #1;
    compare_all();
  endtask

  // Press a key, then idle until the model says the update is done.
  task automatic press(input int kc);
    int n = 0;
    step(1, kc, 0);
    while (m_pend > 0 && n < 8) begin
      step(0, 0, 0);
      n++;
    end
  endtask

  // Asynchronous reset pulse taken mid-cycle; outputs must clear at once.
  task automatic async_reset();
    rst = 1'b0;
    #1;
    check("rst_op_valid", int'(op_valid), 0);
    check("rst_op_value", int'(op_value), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bcd", int'(mag_bcd), 0);
    check("rst_count", int'(digit_count), 0);
    check("rst_neg_ovf", int'({neg, overflow}), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0; key_valid = 1'b0; key_code = 4'h0; op_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_op_valid", int'(op_valid), 0);
    check("reset_op_value", int'(op_value), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_bcd", int'(mag_bcd), 0);
    @(negedge clk);
    rst = 1'b1;

    // 1,2,3 enter, consumer ready.
    press(1); press(2); press(3);
    check("t1_bcd", int'(mag_bcd), 'h123);
    step(1, 11, 1);
    check("t1_valid", int'(op_valid), 1);
    check("t1_value", int'(op_value), 'h7B);
    step(0, 0, 1);
    check("t1_done", int'({op_valid, mag_bcd, digit_count}), 0);

    // sign,1,2,8 enter -> -128.
    press(10); press(1); press(2); press(8);
    check("t2_neg", int'(neg), 1);
    step(1, 11, 0);
    check("t2_value", int'(op_value), 'h80);
    check("t2_ovf", int'(overflow), 0);
    step(0, 0, 1);
    // 1,2,8 positive: 128 exceeds +127.
    press(1); press(2); press(8);
    check("t2_rej_ovf", int'(overflow), 1);
    check("t2_rej_bcd", int'(mag_bcd), 'h012);
    check("t2_rej_cnt", int'(digit_count), 2);
    press(12);

    // 0,0,7 then a fourth digit.
    press(0); press(0); press(7); press(5);
    check("t3_ovf", int'(overflow), 1);
    check("t3_cnt", int'(digit_count), 3);
    step(1, 11, 0);
    check("t3_value", int'(op_value), 'h07);
    check("t3_ovf_clr", int'(overflow), 0);
    step(0, 0, 1);

    // Digit 9 with keys arriving during MUL8 and ADD.
    step(1, 9, 0); step(1, 1, 0); step(1, 1, 0);
    check("t4_cnt", int'(digit_count), 1);
    check("t4_bcd", int'(mag_bcd), 'h009);
    step(1, 11, 0);
    check("t4_value", int'(op_value), 9);
    step(0, 0, 1);

    // 45 enter, consumer stalls for 20 cycles while keys are typed.
    press(4); press(5);
    step(1, 11, 0);
    for (int i = 0; i < 20; i++) step(1, $urandom_range(0, 15), 0);
    check("t5_held_valid", int'(op_valid), 1);
    check("t5_held_value", int'(op_value), 'h2D);
    step(1, 3, 1);
    check("t5_xfer", int'(op_valid), 0);
    check("t5_idle_cnt", int'(digit_count), 0);

    // Reset during ADD, then enter is ignored.
    step(1, 9, 0); step(0, 0, 0);
    async_reset();
    step(1, 11, 1);
    check("t6_add_noop", int'(op_valid), 0);
    // Reset during HOLD.
    press(3); step(1, 11, 0);
    async_reset();
    step(1, 11, 1);
    check("t6_hold_noop", int'(op_valid), 0);

    // Sign toggle at -128 must be refused.
    press(10); press(1); press(2); press(8); press(10);
    check("t7_sign_rej", int'({neg, overflow}), 3);
    press(12);

    // Randomized key stream.
    for (int i = 0; i < 3000; i++) begin
      int kv, kc, sel;
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        continue;
      end
      kv  = ($urandom_range(0, 99) < 45) ? 1 : 0;
      sel = $urandom_range(0, 99);
      if (sel < 60)      kc = $urandom_range(0, 9);
      else if (sel < 70) kc = 10;
      else if (sel < 80) kc = 11;
      else if (sel < 86) kc = 12;
      else               kc = $urandom_range(13, 15);
      step(kv, kc, ($urandom_range(0, 3) == 0) ? 1 : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_operand_entry.md
Name: keypad_operand_entry

Overview:
- Converts a stream of decoded keypad codes into a signed two's-complement operand for the Booth multiplier.
- Performs the reverse of the display path: decimal digits go to binary, where the display path takes binary to BCD.
- Sits between the row scanner (key_valid/key_code) and the multiplier operand inputs.
- Delivers each finished operand with a valid/ready handshake and keeps a BCD echo of the digits typed so far for the 7-segment display.

Parameters:
WIDTH, 8, operand width in bits (signed two's complement).
MAX_DIGITS, 3, maximum decimal digits accepted per operand.

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low (asserted at 0)
key_valid  input  1  one-cycle pulse; key_code valid this cycle
key_code  input  4  0x0-0x9 digit; 0xA sign toggle; 0xB enter; 0xC clear; 0xD-0xF ignored
op_ready  input  1  consumer ready for the operand
op_valid  output  1  op_value is valid and held
op_value  output  WIDTH  signed operand
neg  output  1  current sign of the entry
mag_bcd  output  12  BCD echo of the entered digits, least-significant digit in [3:0]
digit_count  output  2  number of digits accepted so far
busy  output  1  update in progress or operand pending; keys are dropped
overflow  output  1  sticky error flag; cleared by clear, enter, or handshake

Behaviour:
- Reset (rst=0, async) forces state IDLE and zeroes every register: op_valid=0, op_value=0, neg=0, mag_bcd=0, digit_count=0, busy=0, overflow=0, internal magnitude mag=0 (10 bits).
- States:
  - IDLE: no digits entered.
  - ENTRY: at least one digit entered.
  - MUL8: mag_tmp <= mag<<3.
  - ADD: mag <= mag_tmp + (mag<<1) + digit.
  - HOLD: operand offered downstream.
- busy=1 in MUL8, ADD and HOLD. Any key_valid while busy is dropped silently, with no state change.
- Digit accepted in IDLE/ENTRY with key_valid at edge N:
  - Candidate = mag*10 + d.
  - Limit is 127 if neg=0, 128 if neg=1.
  - Rejected, with overflow<=1 and no other change, if digit_count==MAX_DIGITS or candidate > limit. The check is combinational at edge N.
  - On accept: edge N enters MUL8; edge N+1 enters ADD; edge N+2 updates mag, shifts mag_bcd <= {mag_bcd[7:0], d}, increments digit_count, and moves to ENTRY. Keys are accepted again from edge N+3.
  - Leading zero in IDLE is accepted; digit_count increments.
- Sign toggle (0xA) in IDLE/ENTRY: neg <= ~neg, same cycle. Rejected with overflow<=1 if it would make mag out of range (neg=1, mag=128 -> +128 is illegal).
- Clear (0xC) in IDLE/ENTRY: returns to IDLE and zeroes mag, mag_bcd, digit_count, neg and overflow.
- Enter (0xB):
  - In IDLE: ignored.
  - In ENTRY: op_value <= neg ? -mag : mag (WIDTH-bit two's complement), op_valid<=1, overflow<=0, state HOLD.
  - -0 yields 0.
- HOLD:
  - op_value and op_valid are held stable until a cycle with op_valid & op_ready.
  - At that edge: op_valid<=0, and mag, mag_bcd, digit_count and neg are zeroed. State returns to IDLE.
  - op_ready before op_valid has no effect. Transfer completes the edge after op_valid if op_ready is already high.
- Simultaneous events: only one key can arrive per cycle. A key arriving in the same cycle as the HOLD handshake is dropped.
- Reset mid-update (MUL8/ADD) or mid-HOLD discards all partial state. The operand is not delivered.

Test Plan:
- Keys 1,2,3,enter; op_ready=1 -> op_valid for 1 cycle, op_value=0x7B, mag_bcd=0x123 before handshake, all cleared afterwards.
- Keys sign,1,2,8,enter -> op_value=0x80, neg=1, overflow=0. Then keys 1,2,8 with neg=0 -> third digit rejected, overflow=1, mag_bcd=0x012, digit_count=2.
- Keys 0,0,7, then a fourth digit 5 -> 5 rejected, overflow=1. Enter -> op_value=0x07, overflow cleared.
- Digit 9 then a second key_valid 1 and 2 cycles later (during MUL8/ADD) -> second key dropped, mag=9, digit_count=1.
- Entry 45 then enter with op_ready=0 for 20 cycles -> op_valid held, op_value=0x2D stable, further keys dropped. op_ready=1 -> transfer on that edge, state IDLE.
- Reset pulse (rst=0) during ADD, and separately during HOLD -> all outputs 0 immediately (async), no operand delivered. Enter afterwards is ignored (IDLE).
